// File: rtl/ntt_layer_sequencer_if.sv
// Sequencer <-> RAM/butterfly bundle: control handshake, read/write addresses, twiddle index.
// master = sequencer, slave = datapath/environment side.
interface ntt_layer_sequencer_if;
    logic       start;
    logic       inverse;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic       bf_valid;
    logic       bf_inverse;
    logic [6:0] zeta_idx;
    logic       bf_valid_out;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;
    logic [2:0] layer;
    logic       err;

    modport master (
        input  start, inverse, bf_valid_out,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, bf_valid, bf_inverse,
               zeta_idx, wr_en, wr_addr_a, wr_addr_b, layer, err
    );

    modport slave (
        output start, inverse, bf_valid_out,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, bf_valid, bf_inverse,
               zeta_idx, wr_en, wr_addr_a, wr_addr_b, layer, err
    );
endinterface

// File: rtl/ntt_layer_sequencer.sv
// Sweeps a 256-point Kyber NTT/INTT through one butterfly: one pair read per cycle, in-place write RD_LAT+BF_LAT later.
// No backpressure: reads issue back-to-back per layer; err is sticky when bf_valid_out disagrees with wr_en.
module ntt_layer_sequencer #(
    parameter int RD_LAT  = 1,
    parameter int BF_LAT  = 3,
    parameter int NLAYERS = 7
) (
    input  logic                  clk,
    input  logic                  r,
    ntt_layer_sequencer_if.master bus
);
    localparam int WR_LAT = RD_LAT + BF_LAT;
    localparam int DCW    = $clog2(WR_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t         state, state_nxt;
    logic [6:0]     b, b_nxt;
    logic [2:0]     layer_q, layer_nxt;
    logic [DCW-1:0] dcnt, dcnt_nxt;
    logic           inv_q, inv_nxt;
    logic           accept;
    logic           rd_en;
    logic           err_q;

    logic [2:0]     lg;
    logic [7:0]     len;
    logic [6:0]     len_m1, g, o, zeta_calc;
    logic [7:0]     addr_a, addr_b;
    logic [7:0]     rd_a, rd_b;
    logic [6:0]     rd_zeta;

    logic           rd_vld_sh [RD_LAT];
    logic [6:0]     zeta_sh   [RD_LAT];
    logic           bf_vld_sh [BF_LAT];
    logic [7:0]     addr_a_sh [WR_LAT];
    logic [7:0]     addr_b_sh [WR_LAT];

    always_ff @(posedge clk) begin
        if (r) begin
            state   <= IDLE;
            b       <= '0;
            layer_q <= '0;
            dcnt    <= '0;
            inv_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            b       <= b_nxt;
            layer_q <= layer_nxt;
            dcnt    <= dcnt_nxt;
            inv_q   <= inv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        b_nxt     = b;
        layer_nxt = layer_q;
        dcnt_nxt  = dcnt;
        inv_nxt   = inv_q;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    inv_nxt   = bus.inverse;
                    layer_nxt = '0;
                    b_nxt     = '0;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                b_nxt = b + 7'd1;
                if (b == 7'd127) begin
                    dcnt_nxt  = '0;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                dcnt_nxt = dcnt + 1'b1;
                // Hold off the next layer until every write of this one has landed.
                if (dcnt == DCW'(WR_LAT - 1)) begin
                    if (layer_q == 3'(NLAYERS - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        layer_nxt = layer_q + 3'd1;
                        b_nxt     = '0;
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_en = (state == ISSUE);

    // lg = log2(len): forward 7..1, inverse 1..7.
    always_comb begin
        lg        = inv_q ? (layer_q + 3'd1) : (3'd7 - layer_q);
        len       = 8'd1 << lg;
        len_m1    = 7'(len - 8'd1);
        g         = b >> lg;
        o         = b & len_m1;
        addr_a    = ({1'b0, g} << ({1'b0, lg} + 4'd1)) | {1'b0, o};
        addr_b    = addr_a + len;
        zeta_calc = inv_q ? 7'((9'd256 >> lg) - 9'd1 - {2'b00, g})
                          : 7'((8'd128 >> lg) + {1'b0, g});
        rd_a      = rd_en ? addr_a    : 8'd0;
        rd_b      = rd_en ? addr_b    : 8'd0;
        rd_zeta   = rd_en ? zeta_calc : 7'd0;
    end

    always_ff @(posedge clk) begin
        if (r) begin
            for (int i = 0; i < RD_LAT; i++) begin
                rd_vld_sh[i] <= 1'b0;
                zeta_sh[i]   <= '0;
            end
            for (int i = 0; i < BF_LAT; i++) bf_vld_sh[i] <= 1'b0;
            for (int i = 0; i < WR_LAT; i++) begin
                addr_a_sh[i] <= '0;
                addr_b_sh[i] <= '0;
            end
        end else begin
            rd_vld_sh[0] <= rd_en;
            zeta_sh[0]   <= rd_zeta;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld_sh[i] <= rd_vld_sh[i-1];
                zeta_sh[i]   <= zeta_sh[i-1];
            end
            bf_vld_sh[0] <= rd_vld_sh[RD_LAT-1];
            for (int i = 1; i < BF_LAT; i++) bf_vld_sh[i] <= bf_vld_sh[i-1];
            addr_a_sh[0] <= rd_a;
            addr_b_sh[0] <= rd_b;
            for (int i = 1; i < WR_LAT; i++) begin
                addr_a_sh[i] <= addr_a_sh[i-1];
                addr_b_sh[i] <= addr_b_sh[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r || accept) begin
            err_q <= 1'b0;
        end else if (bus.bf_valid_out != bf_vld_sh[BF_LAT-1]) begin
            err_q <= 1'b1;
        end
    end

    assign bus.busy       = (state == ISSUE) || (state == DRAIN);
    assign bus.done       = (state == DONE);
    assign bus.rd_en      = rd_en;
    assign bus.rd_addr_a  = rd_a;
    assign bus.rd_addr_b  = rd_b;
    assign bus.bf_valid   = rd_vld_sh[RD_LAT-1];
    assign bus.bf_inverse = inv_q;
    assign bus.zeta_idx   = zeta_sh[RD_LAT-1];
    assign bus.wr_en      = bf_vld_sh[BF_LAT-1];
    assign bus.wr_addr_a  = addr_a_sh[WR_LAT-1];
    assign bus.wr_addr_b  = addr_b_sh[WR_LAT-1];
    assign bus.layer      = layer_q;
    assign bus.err        = err_q;
endmodule
